// File: rtl/idu_alu_issue_queue_pkg.sv
// Shared definitions for the integer ALU issue queue.
// Holds the datapath widths and the ALU opcode constants. It also holds the
// packed layout of one queue entry and a small readiness helper used by the
// entry storage.
package idu_alu_issue_queue_pkg;

  localparam int XLEN   = 64;
  localparam int PREG_W = 6;
  localparam int IID_W  = 5;

  // Major opcodes of the integer ops that are routed to the ALU pipe
  localparam logic [6:0] R_ALU64 = 7'b0110011;
  localparam logic [6:0] R_ALU32 = 7'b0111011;
  localparam logic [6:0] I_ALU64 = 7'b0010011;
  localparam logic [6:0] I_ALU32 = 7'b0011011;
  localparam logic [6:0] U_LUI   = 7'b0110111;
  localparam logic [6:0] U_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [IID_W-1:0]  iid;
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic              psrc1_vld;
    logic [PREG_W-1:0] psrc1_preg;
    logic              psrc1_rdy;
    logic [XLEN-1:0]   psrc1_value;
    logic              psrc2_vld;
    logic [PREG_W-1:0] psrc2_preg;
    logic              psrc2_rdy;
    logic [XLEN-1:0]   psrc2_value;
    logic              pdst_vld;
    logic [PREG_W-1:0] pdst;
    logic              imm_vld;
    logic [XLEN-1:0]   imm;
  } aiq_entry_t;

  // An unused source never blocks issue
  function automatic logic src_ready(input logic used, input logic rdy);
    return ~used | rdy;
  endfunction

endpackage

// File: rtl/idu_alu_issue_queue_if.sv
// Bundle of the issue queue's dispatch, wakeup and issue buses.
//   dispatch : idu_aiq_dp_*        (IDU -> queue, dp_rdy back)
//   wakeup   : exu_idu_rf_*_wb_*   (ALU / LSU writeback -> queue)
//   issue    : idu_exu_alu_*       (queue -> ALU pipe)
// master = the surrounding pipeline, slave = the issue queue.
interface idu_alu_issue_queue_if;
  import idu_alu_issue_queue_pkg::*;

  logic              idu_aiq_dp_vld;
  logic              idu_aiq_dp_rdy;
  logic [IID_W-1:0]  idu_aiq_dp_iid;
  logic [6:0]        idu_aiq_dp_opcode;
  logic [6:0]        idu_aiq_dp_funct7;
  logic [2:0]        idu_aiq_dp_funct3;
  logic [XLEN-1:0]   idu_aiq_dp_pc;
  logic              idu_aiq_dp_psrc1_vld;
  logic [PREG_W-1:0] idu_aiq_dp_psrc1_preg;
  logic              idu_aiq_dp_psrc1_rdy;
  logic [XLEN-1:0]   idu_aiq_dp_psrc1_value;
  logic              idu_aiq_dp_psrc2_vld;
  logic [PREG_W-1:0] idu_aiq_dp_psrc2_preg;
  logic              idu_aiq_dp_psrc2_rdy;
  logic [XLEN-1:0]   idu_aiq_dp_psrc2_value;
  logic              idu_aiq_dp_pdst_vld;
  logic [PREG_W-1:0] idu_aiq_dp_pdst;
  logic              idu_aiq_dp_imm_vld;
  logic [XLEN-1:0]   idu_aiq_dp_imm;

  logic              exu_idu_rf_alu_wb_vld;
  logic [PREG_W-1:0] exu_idu_rf_alu_wb_preg;
  logic [XLEN-1:0]   exu_idu_rf_alu_wb_data;
  logic              exu_idu_rf_lsu_wb_vld;
  logic [PREG_W-1:0] exu_idu_rf_lsu_wb_preg;
  logic [XLEN-1:0]   exu_idu_rf_lsu_wb_data;

  logic              idu_exu_alu_vld;
  logic [IID_W-1:0]  idu_exu_alu_iid;
  logic [6:0]        idu_exu_alu_opcode;
  logic [6:0]        idu_exu_alu_funct7;
  logic [2:0]        idu_exu_alu_funct3;
  logic [XLEN-1:0]   idu_exu_alu_pc;
  logic              idu_exu_alu_psrc1_vld;
  logic [XLEN-1:0]   idu_exu_alu_psrc1_value;
  logic              idu_exu_alu_psrc2_vld;
  logic [XLEN-1:0]   idu_exu_alu_psrc2_value;
  logic              idu_exu_alu_pdst_vld;
  logic [PREG_W-1:0] idu_exu_alu_pdst;
  logic              idu_exu_alu_imm_vld;
  logic [XLEN-1:0]   idu_exu_alu_imm;

  modport master (
    output idu_aiq_dp_vld, idu_aiq_dp_iid, idu_aiq_dp_opcode, idu_aiq_dp_funct7,
           idu_aiq_dp_funct3, idu_aiq_dp_pc, idu_aiq_dp_psrc1_vld, idu_aiq_dp_psrc1_preg,
           idu_aiq_dp_psrc1_rdy, idu_aiq_dp_psrc1_value, idu_aiq_dp_psrc2_vld,
           idu_aiq_dp_psrc2_preg, idu_aiq_dp_psrc2_rdy, idu_aiq_dp_psrc2_value,
           idu_aiq_dp_pdst_vld, idu_aiq_dp_pdst, idu_aiq_dp_imm_vld, idu_aiq_dp_imm,
           exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data,
           exu_idu_rf_lsu_wb_vld, exu_idu_rf_lsu_wb_preg, exu_idu_rf_lsu_wb_data,
    input  idu_aiq_dp_rdy, idu_exu_alu_vld, idu_exu_alu_iid, idu_exu_alu_opcode,
           idu_exu_alu_funct7, idu_exu_alu_funct3, idu_exu_alu_pc, idu_exu_alu_psrc1_vld,
           idu_exu_alu_psrc1_value, idu_exu_alu_psrc2_vld, idu_exu_alu_psrc2_value,
           idu_exu_alu_pdst_vld, idu_exu_alu_pdst, idu_exu_alu_imm_vld, idu_exu_alu_imm
  );

  modport slave (
    input  idu_aiq_dp_vld, idu_aiq_dp_iid, idu_aiq_dp_opcode, idu_aiq_dp_funct7,
           idu_aiq_dp_funct3, idu_aiq_dp_pc, idu_aiq_dp_psrc1_vld, idu_aiq_dp_psrc1_preg,
           idu_aiq_dp_psrc1_rdy, idu_aiq_dp_psrc1_value, idu_aiq_dp_psrc2_vld,
           idu_aiq_dp_psrc2_preg, idu_aiq_dp_psrc2_rdy, idu_aiq_dp_psrc2_value,
           idu_aiq_dp_pdst_vld, idu_aiq_dp_pdst, idu_aiq_dp_imm_vld, idu_aiq_dp_imm,
           exu_idu_rf_alu_wb_vld, exu_idu_rf_alu_wb_preg, exu_idu_rf_alu_wb_data,
           exu_idu_rf_lsu_wb_vld, exu_idu_rf_lsu_wb_preg, exu_idu_rf_lsu_wb_data,
    output idu_aiq_dp_rdy, idu_exu_alu_vld, idu_exu_alu_iid, idu_exu_alu_opcode,
           idu_exu_alu_funct7, idu_exu_alu_funct3, idu_exu_alu_pc, idu_exu_alu_psrc1_vld,
           idu_exu_alu_psrc1_value, idu_exu_alu_psrc2_vld, idu_exu_alu_psrc2_value,
           idu_exu_alu_pdst_vld, idu_exu_alu_pdst, idu_exu_alu_imm_vld, idu_exu_alu_imm
  );

endinterface

// File: rtl/idu_alu_issue_queue_entry.sv
// One slot of the ALU issue queue: registered entry contents, the 2x2 tag
// compare against the ALU/LSU writeback buses, and the issue-ready flag.
// Ports:
//   clk, rst_clk (async, active-low), flush : clock, reset, global discard
//   load_vld / load_data : content this slot holds after the next edge
//                          (kept, shifted-in or freshly dispatched)
//   alu_wb_* / lsu_wb_*  : wakeup buses
//   entry_vld / entry_data / entry_rdy : registered slot state and readiness
module idu_aiq_entry
  import idu_alu_issue_queue_pkg::*;
(
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              flush,
  input  logic              load_vld,
  input  aiq_entry_t        load_data,
  input  logic              alu_wb_vld,
  input  logic [PREG_W-1:0] alu_wb_preg,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              lsu_wb_vld,
  input  logic [PREG_W-1:0] lsu_wb_preg,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              entry_vld,
  output aiq_entry_t        entry_data,
  output logic              entry_rdy
);

  aiq_entry_t woken;

  // Wakeup is applied to whatever is loaded, so shifting and newly dispatched
  // ops also catch a writeback in flight. The ALU bus is checked first so it
  // wins when both buses carry the same tag.
  always_comb begin
    woken = load_data;
    if (load_data.psrc1_vld && !load_data.psrc1_rdy) begin
      if (alu_wb_vld && (alu_wb_preg == load_data.psrc1_preg)) begin
        woken.psrc1_rdy   = 1'b1;
        woken.psrc1_value = alu_wb_data;
      end else if (lsu_wb_vld && (lsu_wb_preg == load_data.psrc1_preg)) begin
        woken.psrc1_rdy   = 1'b1;
        woken.psrc1_value = lsu_wb_data;
      end
    end
    if (load_data.psrc2_vld && !load_data.psrc2_rdy) begin
      if (alu_wb_vld && (alu_wb_preg == load_data.psrc2_preg)) begin
        woken.psrc2_rdy   = 1'b1;
        woken.psrc2_value = alu_wb_data;
      end else if (lsu_wb_vld && (lsu_wb_preg == load_data.psrc2_preg)) begin
        woken.psrc2_rdy   = 1'b1;
        woken.psrc2_value = lsu_wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      entry_vld  <= 1'b0;
      entry_data <= '0;
    end else if (flush) begin
      entry_vld  <= 1'b0;
      entry_data <= '0;
    end else begin
      entry_vld <= load_vld;
      if (load_vld) begin
        entry_data <= woken;
      end
    end
  end

  // Readiness only looks at registered state, so a wakeup is issuable one
  // cycle later
  assign entry_rdy = entry_vld
                   & src_ready(entry_data.psrc1_vld, entry_data.psrc1_rdy)
                   & src_ready(entry_data.psrc2_vld, entry_data.psrc2_rdy);

endmodule

// File: rtl/idu_alu_issue_queue.sv
// Collapsing issue queue feeding the single integer ALU pipe.
// Entry 0 is always the oldest. Each cycle the lowest-index ready entry is
// issued and removed, and the younger entries slide down one slot.
// Ports:
//   clk, rst_clk (async, active-low) : clock and reset
//   rtu_global_flush                 : discard every entry
//   bus (slave)                      : dispatch, writeback wakeup and issue buses
//   aiq_cnt                          : number of occupied entries
module idu_alu_issue_queue
  import idu_alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_clk,
  input  logic                       rtu_global_flush,
  idu_alu_issue_queue_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0] aiq_cnt
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SEL_W = $clog2(DEPTH);

  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] ent_rdy;
  aiq_entry_t       ent_data [DEPTH];
  aiq_entry_t       dp_entry;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tail;
  logic [SEL_W-1:0] sel;
  logic             issue_any;
  logic             issue;
  logic             accept;
  logic             dp_rdy;

  always_comb begin
    dp_entry             = '0;
    dp_entry.iid         = bus.idu_aiq_dp_iid;
    dp_entry.opcode      = bus.idu_aiq_dp_opcode;
    dp_entry.funct7      = bus.idu_aiq_dp_funct7;
    dp_entry.funct3      = bus.idu_aiq_dp_funct3;
    dp_entry.pc          = bus.idu_aiq_dp_pc;
    dp_entry.psrc1_vld   = bus.idu_aiq_dp_psrc1_vld;
    dp_entry.psrc1_preg  = bus.idu_aiq_dp_psrc1_preg;
    dp_entry.psrc1_rdy   = bus.idu_aiq_dp_psrc1_rdy;
    dp_entry.psrc1_value = bus.idu_aiq_dp_psrc1_value;
    dp_entry.psrc2_vld   = bus.idu_aiq_dp_psrc2_vld;
    dp_entry.psrc2_preg  = bus.idu_aiq_dp_psrc2_preg;
    dp_entry.psrc2_rdy   = bus.idu_aiq_dp_psrc2_rdy;
    dp_entry.psrc2_value = bus.idu_aiq_dp_psrc2_value;
    dp_entry.pdst_vld    = bus.idu_aiq_dp_pdst_vld;
    dp_entry.pdst        = bus.idu_aiq_dp_pdst;
    dp_entry.imm_vld     = bus.idu_aiq_dp_imm_vld;
    dp_entry.imm         = bus.idu_aiq_dp_imm;
  end

  // Space is judged from the registered count only; a slot freed by this
  // cycle's issue is not offered to dispatch until the next cycle
  assign dp_rdy             = (cnt < CNT_W'(DEPTH));
  assign bus.idu_aiq_dp_rdy = dp_rdy;
  assign accept             = bus.idu_aiq_dp_vld & dp_rdy & ~rtu_global_flush;
  assign issue              = issue_any & ~rtu_global_flush;
  // New op lands one slot lower when an issue collapses the queue this cycle
  assign tail               = cnt - CNT_W'(issue);

  // Oldest-first select: scan from the top so the lowest ready index wins
  always_comb begin
    issue_any = 1'b0;
    sel       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        issue_any = 1'b1;
        sel       = SEL_W'(i);
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic       up_vld;
    aiq_entry_t up_data;
    logic       shift;
    logic       slot_vld;
    aiq_entry_t slot_data;

    if (i < DEPTH - 1) begin : g_up
      assign up_vld  = ent_vld[i+1];
      assign up_data = ent_data[i+1];
    end else begin : g_top
      assign up_vld  = 1'b0;
      assign up_data = '0;
    end

    // Slots at or above the issued one take their upper neighbour's contents
    assign shift = issue && (sel <= SEL_W'(i));

    always_comb begin
      slot_vld  = ent_vld[i];
      slot_data = ent_data[i];
      if (shift) begin
        slot_vld  = up_vld;
        slot_data = up_data;
      end
      if (accept && (tail == CNT_W'(i))) begin
        slot_vld  = 1'b1;
        slot_data = dp_entry;
      end
    end

    idu_aiq_entry u_entry (
      .clk        (clk),
      .rst_clk    (rst_clk),
      .flush      (rtu_global_flush),
      .load_vld   (slot_vld),
      .load_data  (slot_data),
      .alu_wb_vld (bus.exu_idu_rf_alu_wb_vld),
      .alu_wb_preg(bus.exu_idu_rf_alu_wb_preg),
      .alu_wb_data(bus.exu_idu_rf_alu_wb_data),
      .lsu_wb_vld (bus.exu_idu_rf_lsu_wb_vld),
      .lsu_wb_preg(bus.exu_idu_rf_lsu_wb_preg),
      .lsu_wb_data(bus.exu_idu_rf_lsu_wb_data),
      .entry_vld  (ent_vld[i]),
      .entry_data (ent_data[i]),
      .entry_rdy  (ent_rdy[i])
    );
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      cnt <= '0;
    end else if (rtu_global_flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(accept) - CNT_W'(issue);
    end
  end

  assign aiq_cnt = cnt;

  // Issue fields are forced to zero whenever nothing issues
  assign bus.idu_exu_alu_vld         = issue;
  assign bus.idu_exu_alu_iid         = issue ? ent_data[sel].iid         : '0;
  assign bus.idu_exu_alu_opcode      = issue ? ent_data[sel].opcode      : '0;
  assign bus.idu_exu_alu_funct7      = issue ? ent_data[sel].funct7      : '0;
  assign bus.idu_exu_alu_funct3      = issue ? ent_data[sel].funct3      : '0;
  assign bus.idu_exu_alu_pc          = issue ? ent_data[sel].pc          : '0;
  assign bus.idu_exu_alu_psrc1_vld   = issue ? ent_data[sel].psrc1_vld   : 1'b0;
  assign bus.idu_exu_alu_psrc1_value = issue ? ent_data[sel].psrc1_value : '0;
  assign bus.idu_exu_alu_psrc2_vld   = issue ? ent_data[sel].psrc2_vld   : 1'b0;
  assign bus.idu_exu_alu_psrc2_value = issue ? ent_data[sel].psrc2_value : '0;
  assign bus.idu_exu_alu_pdst_vld    = issue ? ent_data[sel].pdst_vld    : 1'b0;
  assign bus.idu_exu_alu_pdst        = issue ? ent_data[sel].pdst        : '0;
  assign bus.idu_exu_alu_imm_vld     = issue ? ent_data[sel].imm_vld     : 1'b0;
  assign bus.idu_exu_alu_imm         = issue ? ent_data[sel].imm         : '0;

endmodule

// File: tb/tb_idu_alu_issue_queue.sv
// Self-checking bench for idu_alu_issue_queue (DEPTH=4).
// Expected issues are queued when the stimulus that should cause them is
// driven. A negedge monitor pops and compares them whenever the queue issues.
module tb_idu_alu_issue_queue;
  import idu_alu_issue_queue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_clk = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] aiq_cnt;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;

  typedef struct {
    logic [IID_W-1:0] iid;
    logic             s1_vld;
    logic [63:0]      s1_val;
    logic             s2_vld;
    logic [63:0]      s2_val;
  } exp_t;

  exp_t exp_q[$];

  idu_alu_issue_queue_if bus();

  idu_alu_issue_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst_clk         (rst_clk),
    .rtu_global_flush(flush),
    .bus             (bus),
    .aiq_cnt         (aiq_cnt)
  );

  always #5 clk = ~clk;

  // Op fields are derived from the iid so each issued op can be recognised
  function automatic logic [63:0] pc_of(input logic [IID_W-1:0] iid);
    return 64'h8000_0000 + {57'h0, iid, 2'b00};
  endfunction

  function automatic logic [6:0] op_of(input logic [IID_W-1:0] iid);
    return iid[0] ? I_ALU64 : (iid[1] ? R_ALU32 : R_ALU64);
  endfunction

  function automatic logic [63:0] imm_of(input logic [IID_W-1:0] iid);
    return 64'h0000_1000 + {59'h0, iid};
  endfunction

  function automatic logic [17:0] ctrl_of(input logic [IID_W-1:0] iid);
    return {2'b00, iid, iid[2:0], 1'b1, 1'b1, iid, iid[0]};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_dispatch(input logic [4:0] iid,
                                input logic s1v, input logic [5:0] s1p, input logic s1r,
                                input logic [63:0] s1val,
                                input logic s2v, input logic [5:0] s2p, input logic s2r,
                                input logic [63:0] s2val);
    bus.idu_aiq_dp_vld         = 1'b1;
    bus.idu_aiq_dp_iid         = iid;
    bus.idu_aiq_dp_opcode      = op_of(iid);
    bus.idu_aiq_dp_funct7      = {2'b00, iid};
    bus.idu_aiq_dp_funct3      = iid[2:0];
    bus.idu_aiq_dp_pc          = pc_of(iid);
    bus.idu_aiq_dp_psrc1_vld   = s1v;
    bus.idu_aiq_dp_psrc1_preg  = s1p;
    bus.idu_aiq_dp_psrc1_rdy   = s1r;
    bus.idu_aiq_dp_psrc1_value = s1val;
    bus.idu_aiq_dp_psrc2_vld   = s2v;
    bus.idu_aiq_dp_psrc2_preg  = s2p;
    bus.idu_aiq_dp_psrc2_rdy   = s2r;
    bus.idu_aiq_dp_psrc2_value = s2val;
    bus.idu_aiq_dp_pdst_vld    = 1'b1;
    bus.idu_aiq_dp_pdst        = {1'b1, iid};
    bus.idu_aiq_dp_imm_vld     = iid[0];
    bus.idu_aiq_dp_imm         = imm_of(iid);
  endtask

  task automatic wb_alu(input logic [5:0] preg, input logic [63:0] data);
    bus.exu_idu_rf_alu_wb_vld  = 1'b1;
    bus.exu_idu_rf_alu_wb_preg = preg;
    bus.exu_idu_rf_alu_wb_data = data;
  endtask

  task automatic wb_lsu(input logic [5:0] preg, input logic [63:0] data);
    bus.exu_idu_rf_lsu_wb_vld  = 1'b1;
    bus.exu_idu_rf_lsu_wb_preg = preg;
    bus.exu_idu_rf_lsu_wb_data = data;
  endtask

  task automatic expect_issue(input logic [4:0] iid, input logic s1v, input logic [63:0] s1val,
                              input logic s2v, input logic [63:0] s2val);
    exp_t e;
    e.iid    = iid;
    e.s1_vld = s1v;
    e.s1_val = s1val;
    e.s2_vld = s2v;
    e.s2_val = s2val;
    exp_q.push_back(e);
  endtask

  // Let the currently driven inputs take effect at one clock edge, then
  // return the one-shot controls to idle
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    bus.idu_aiq_dp_vld        = 1'b0;
    bus.exu_idu_rf_alu_wb_vld = 1'b0;
    bus.exu_idu_rf_lsu_wb_vld = 1'b0;
    flush                     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.idu_exu_alu_vld) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_issue_vld", 64'(bus.idu_exu_alu_vld), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("iss_iid", 64'(bus.idu_exu_alu_iid), 64'(e.iid));
          check_output("iss_opcode", 64'(bus.idu_exu_alu_opcode), 64'(op_of(e.iid)));
          check_output("iss_pc", bus.idu_exu_alu_pc, pc_of(e.iid));
          check_output("iss_psrc1_vld", 64'(bus.idu_exu_alu_psrc1_vld), 64'(e.s1_vld));
          check_output("iss_psrc1_value", bus.idu_exu_alu_psrc1_value, e.s1_val);
          check_output("iss_psrc2_vld", 64'(bus.idu_exu_alu_psrc2_vld), 64'(e.s2_vld));
          check_output("iss_psrc2_value", bus.idu_exu_alu_psrc2_value, e.s2_val);
          check_output("iss_ctrl",
                       64'({bus.idu_exu_alu_funct7, bus.idu_exu_alu_funct3,
                            bus.idu_exu_alu_pdst_vld, bus.idu_exu_alu_pdst,
                            bus.idu_exu_alu_imm_vld}),
                       64'(ctrl_of(e.iid)));
          check_output("iss_imm", bus.idu_exu_alu_imm, imm_of(e.iid));
        end
      end else begin
        check_output("idle_fields_zero",
                     64'(|{bus.idu_exu_alu_iid, bus.idu_exu_alu_opcode, bus.idu_exu_alu_funct7,
                           bus.idu_exu_alu_funct3, bus.idu_exu_alu_pc,
                           bus.idu_exu_alu_psrc1_vld, bus.idu_exu_alu_psrc1_value,
                           bus.idu_exu_alu_psrc2_vld, bus.idu_exu_alu_psrc2_value,
                           bus.idu_exu_alu_pdst_vld, bus.idu_exu_alu_pdst,
                           bus.idu_exu_alu_imm_vld, bus.idu_exu_alu_imm}),
                     64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.idu_aiq_dp_vld         = 1'b0;
    bus.idu_aiq_dp_iid         = '0;
    bus.idu_aiq_dp_opcode      = '0;
    bus.idu_aiq_dp_funct7      = '0;
    bus.idu_aiq_dp_funct3      = '0;
    bus.idu_aiq_dp_pc          = '0;
    bus.idu_aiq_dp_psrc1_vld   = 1'b0;
    bus.idu_aiq_dp_psrc1_preg  = '0;
    bus.idu_aiq_dp_psrc1_rdy   = 1'b0;
    bus.idu_aiq_dp_psrc1_value = '0;
    bus.idu_aiq_dp_psrc2_vld   = 1'b0;
    bus.idu_aiq_dp_psrc2_preg  = '0;
    bus.idu_aiq_dp_psrc2_rdy   = 1'b0;
    bus.idu_aiq_dp_psrc2_value = '0;
    bus.idu_aiq_dp_pdst_vld    = 1'b0;
    bus.idu_aiq_dp_pdst        = '0;
    bus.idu_aiq_dp_imm_vld     = 1'b0;
    bus.idu_aiq_dp_imm         = '0;
    bus.exu_idu_rf_alu_wb_vld  = 1'b0;
    bus.exu_idu_rf_alu_wb_preg = '0;
    bus.exu_idu_rf_alu_wb_data = '0;
    bus.exu_idu_rf_lsu_wb_vld  = 1'b0;
    bus.exu_idu_rf_lsu_wb_preg = '0;
    bus.exu_idu_rf_lsu_wb_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_cnt", 64'(aiq_cnt), 64'd0);
    check_output("rst_dp_rdy", 64'(bus.idu_aiq_dp_rdy), 64'd1);
    check_output("rst_alu_vld", 64'(bus.idu_exu_alu_vld), 64'd0);
    rst_clk = 1'b1;
    mon_en  = 1'b1;
    apply_stimulus();

    // 1: a fully ready op issues the cycle after dispatch
    $display("[TB] test 1: ready op");
    drive_dispatch(5'd3, 1'b1, 6'd1, 1'b1, 64'h11, 1'b1, 6'd2, 1'b1, 64'h22);
    expect_issue(5'd3, 1'b1, 64'h11, 1'b1, 64'h22);
    apply_stimulus();
    check_output("t1_cnt_one", 64'(aiq_cnt), 64'd1);
    check_output("t1_alu_vld", 64'(bus.idu_exu_alu_vld), 64'd1);
    apply_stimulus();
    check_output("t1_cnt_zero", 64'(aiq_cnt), 64'd0);

    // 2: a younger ready op bypasses older waiting ones; wakeup then drains in order
    $display("[TB] test 2: out-of-order issue and wakeup");
    drive_dispatch(5'd1, 1'b1, 6'd9, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    drive_dispatch(5'd2, 1'b1, 6'd9, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    drive_dispatch(5'd4, 1'b1, 6'd5, 1'b1, 64'h44, 1'b0, 6'd0, 1'b0, 64'h0);
    expect_issue(5'd4, 1'b1, 64'h44, 1'b0, 64'h0);
    apply_stimulus();
    check_output("t2_cnt_three", 64'(aiq_cnt), 64'd3);
    wb_alu(6'd9, 64'h55);
    expect_issue(5'd1, 1'b1, 64'h55, 1'b0, 64'h0);
    expect_issue(5'd2, 1'b1, 64'h55, 1'b0, 64'h0);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("t2_cnt_zero", 64'(aiq_cnt), 64'd0);

    // 3: full queue blocks dispatch; middle issue collapses, wakeup while shifting
    $display("[TB] test 3: full queue and collapse");
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(5'(10 + k), 1'b1, 6'(20 + k), 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
      apply_stimulus();
    end
    check_output("t3_cnt_full", 64'(aiq_cnt), 64'd4);
    check_output("t3_dp_rdy_full", 64'(bus.idu_aiq_dp_rdy), 64'd0);
    drive_dispatch(5'd14, 1'b0, 6'd0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    check_output("t3_cnt_ignored", 64'(aiq_cnt), 64'd4);
    wb_lsu(6'd22, 64'h77);
    expect_issue(5'd12, 1'b1, 64'h77, 1'b0, 64'h0);
    apply_stimulus();
    check_output("t3_dp_rdy_no_credit", 64'(bus.idu_aiq_dp_rdy), 64'd0);
    check_output("t3_mid_issue_vld", 64'(bus.idu_exu_alu_vld), 64'd1);
    apply_stimulus();
    check_output("t3_cnt_three", 64'(aiq_cnt), 64'd3);
    check_output("t3_dp_rdy_back", 64'(bus.idu_aiq_dp_rdy), 64'd1);
    wb_alu(6'd20, 64'hA0);
    wb_lsu(6'd21, 64'hA1);
    expect_issue(5'd10, 1'b1, 64'hA0, 1'b0, 64'h0);
    expect_issue(5'd11, 1'b1, 64'hA1, 1'b0, 64'h0);
    apply_stimulus();
    wb_alu(6'd23, 64'hA3);
    expect_issue(5'd13, 1'b1, 64'hA3, 1'b0, 64'h0);
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("t3_cnt_zero", 64'(aiq_cnt), 64'd0);

    // 4: wakeup in the dispatch cycle, and ALU bus priority over LSU
    $display("[TB] test 4: dispatch-cycle wakeup and bus priority");
    drive_dispatch(5'd5, 1'b1, 6'd1, 1'b1, 64'h1, 1'b1, 6'd30, 1'b0, 64'h0);
    wb_alu(6'd30, 64'hAB);
    expect_issue(5'd5, 1'b1, 64'h1, 1'b1, 64'hAB);
    apply_stimulus();
    apply_stimulus();
    drive_dispatch(5'd6, 1'b0, 6'd0, 1'b0, 64'h0, 1'b1, 6'd31, 1'b0, 64'h0);
    apply_stimulus();
    wb_alu(6'd31, 64'hA1);
    wb_lsu(6'd31, 64'hB2);
    expect_issue(5'd6, 1'b0, 64'h0, 1'b1, 64'hA1);
    apply_stimulus();
    apply_stimulus();
    check_output("t4_cnt_zero", 64'(aiq_cnt), 64'd0);

    // 5: flush wins over a ready entry and a simultaneous dispatch
    $display("[TB] test 5: global flush");
    drive_dispatch(5'd7, 1'b1, 6'd40, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    drive_dispatch(5'd8, 1'b1, 6'd41, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    drive_dispatch(5'd9, 1'b1, 6'd42, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    check_output("t5_cnt_three", 64'(aiq_cnt), 64'd3);
    wb_alu(6'd40, 64'hF0);
    apply_stimulus();
    flush = 1'b1;
    drive_dispatch(5'd15, 1'b0, 6'd0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    #1;
    check_output("t5_flush_alu_vld", 64'(bus.idu_exu_alu_vld), 64'd0);
    apply_stimulus();
    check_output("t5_cnt_after_flush", 64'(aiq_cnt), 64'd0);
    repeat (3) apply_stimulus();
    check_output("t5_cnt_still_zero", 64'(aiq_cnt), 64'd0);

    // 6: asynchronous reset in the middle of an issue
    $display("[TB] test 6: mid-stream reset");
    drive_dispatch(5'd17, 1'b1, 6'd50, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    drive_dispatch(5'd18, 1'b1, 6'd50, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    drive_dispatch(5'd19, 1'b0, 6'd0, 1'b0, 64'h0, 1'b0, 6'd0, 1'b0, 64'h0);
    apply_stimulus();
    rst_clk = 1'b0;
    #1;
    check_output("t6_rst_alu_vld", 64'(bus.idu_exu_alu_vld), 64'd0);
    check_output("t6_rst_cnt", 64'(aiq_cnt), 64'd0);
    check_output("t6_rst_dp_rdy", 64'(bus.idu_aiq_dp_rdy), 64'd1);
    @(posedge clk);
    #1;
    rst_clk = 1'b1;
    wb_alu(6'd50, 64'h5);
    apply_stimulus();
    check_output("t6_no_survivor", 64'(aiq_cnt), 64'd0);
    drive_dispatch(5'd20, 1'b1, 6'd3, 1'b1, 64'h33, 1'b1, 6'd4, 1'b1, 64'h44);
    expect_issue(5'd20, 1'b1, 64'h33, 1'b1, 64'h44);
    apply_stimulus();
    check_output("t6_cnt_one", 64'(aiq_cnt), 64'd1);
    apply_stimulus();
    check_output("t6_cnt_zero", 64'(aiq_cnt), 64'd0);

    repeat (2) apply_stimulus();
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
